memwb: RTL and testbench
========================

// Module: memwb
// PURPOSE
//  Memory/writeback stage, directly downstream of execute. Accepts one committed instruction per
//  cycle; register-only results retire to the register file in the accept cycle. Loads/stores stall
//  the pipeline until the data bus answers; load data then retires. Last stage: never flushed.
// PARAMETERS
//  RW       16  datapath / address width (`RW from config.v)
//  REGNO    8   register count; width of one-hot write enable (`REGNO)
//  TIMEOUT  255 bus cycles before forced fault; 0 disables timeout; counter width $clog2(TIMEOUT+1)
// PORTS
//  i_clk          in   1      clock
//  i_rst          in   1      synchronous reset, active-high
//  o_ready        out  1      stage can accept (to execute i_next_ready)
//  i_submit       in   1      instruction valid from execute
//  i_data         in   RW     ALU/sreg result, or store data when i_mem_access
//  i_addr         in   RW     memory address
//  i_reg_ie       in   REGNO  one-hot destination write enable (0 = no writeback)
//  i_mem_access   in   1      instruction is load/store
//  i_mem_we       in   1      1 = store, 0 = load
//  o_reg_ie       out  REGNO  register file write enable (to execute i_reg_ie)
//  o_reg_data     out  RW     register file write data (to execute i_reg_data)
//  o_mem_req      out  1      bus request, held until ack/err/timeout
//  o_mem_we       out  1      bus write
//  o_mem_addr     out  RW     bus address
//  o_mem_data     out  RW     bus write data
//  i_mem_data     in   RW     bus read data, valid with i_mem_ack
//  i_mem_ack      in   1      bus transfer complete
//  i_mem_err      in   1      bus error, terminates transfer
//  o_bus_fault    out  1      1-cycle pulse: transfer ended by error or timeout
//  o_fault_addr   out  RW     address of last faulting transfer, held
// BEHAVIOUR
//  - Reset: state IDLE, o_mem_req=0, o_mem_we=0, o_mem_addr/o_mem_data=0, o_bus_fault=0,
//    o_fault_addr=0, timeout counter=0. o_ready=1, o_reg_ie=0 follow from IDLE.
//  - States: IDLE, BUS. o_ready = (state==IDLE), combinational from state only.
//  - IDLE, i_submit & ~i_mem_access: o_reg_ie=i_reg_ie, o_reg_data=i_data combinationally,
//    same cycle (0 latency, written at that edge). Stay IDLE.
//  - IDLE, i_submit & i_mem_access: latch addr/data/we/reg_ie; next cycle o_mem_req=1 with
//    registered addr/we/data; -> BUS. No writeback in the accept cycle.
//  - BUS: request fields stable every cycle until termination; counter increments per cycle.
//    Termination: i_mem_err, i_mem_ack, or counter==TIMEOUT-1 (TIMEOUT!=0); priority err > ack > timeout.
//    Termination cycle: o_mem_req drops at next edge; -> IDLE; o_ready=1 only from next cycle
//    (no same-cycle accept, so two writebacks never collide on single write port).
//    Load + ack: o_reg_ie=latched reg_ie, o_reg_data=i_mem_data combinationally in ack cycle.
//    Load + err/timeout: writeback with data 0 in that cycle; o_bus_fault=1 next cycle; o_fault_addr latched.
//    Store: no writeback (o_reg_ie=0) regardless of latched reg_ie; fault reported as for loads.
//  - i_mem_ack/i_mem_err in IDLE: ignored. i_submit while BUS: ignored (execute holds it).
//  - o_reg_ie=0 in every cycle not listed above; o_reg_data don't-care when o_reg_ie=0.
//  - Reset mid-transfer: request abandoned, state IDLE after edge; late ack ignored.
//  - Execute hazard logic relies on: result of any accepted instruction in the RF no later than
//    the edge after which o_ready returns high.
// STRUCTURE
//  - `RW, `REGNO from config.v; state encoding as localparam in this module.
//  - Sub-module: bus_timeout (counter, clear on issue, terminal-count out); rest inline.
// TESTING
//  1 Submit non-mem, i_data=16'h1234, i_reg_ie=8'h04 -> same cycle o_reg_ie=8'h04, o_reg_data=16'h1234, o_ready stays 1.
//  2 Load addr 16'h0100, reg_ie=8'h02, ack after 3 cycles data 16'hBEEF -> o_mem_req 3 cycles, ack cycle
//    o_reg_ie=8'h02 data BEEF, o_ready low from accept+1 to ack cycle, high next.
//  3 Store addr 16'h0200 data 16'h00AA, ack 1 cycle -> o_mem_we=1, o_mem_data=00AA, o_reg_ie never nonzero.
//  4 Load, no ack, TIMEOUT=4 -> req 4 cycles, writeback data 0, o_bus_fault pulse, o_fault_addr=addr.
//  5 i_mem_ack and i_mem_err same cycle on load -> data 0 written, fault pulse (err wins).
//  6 i_rst during BUS, then stray ack -> o_mem_req=0 next cycle, o_ready=1, no writeback.

Source files
------------

// File: rtl/memwb_pkg.sv
// Shared types and default sizing for the memory/writeback stage.
package memwb_pkg;

    localparam int unsigned RW_DEF      = 16;
    localparam int unsigned REGNO_DEF   = 8;
    localparam int unsigned TIMEOUT_DEF = 255;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    // Counter width for a timeout of n cycles; a disabled (0) timeout still needs one bit.
    function automatic int unsigned tmo_width(input int unsigned n);
        return (n == 0) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/memwb_bus_timeout.sv
// Bus watchdog: counts cycles of an outstanding transfer, flags the last allowed cycle.
module bus_timeout
    import memwb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tc
);

    localparam int unsigned CW = tmo_width(TIMEOUT);

    logic [CW-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            cnt <= '0;
        end else if (i_en) begin
            cnt <= cnt + CW'(1);
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_off
            assign o_tc = 1'b0;
        end else begin : g_on
            assign o_tc = i_en && (cnt == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/memwb.sv
// Memory/writeback stage: zero-latency register writeback, stalling single-transfer data bus.
module memwb
    import memwb_pkg::*;
#(
    parameter int unsigned RW      = RW_DEF,
    parameter int unsigned REGNO   = REGNO_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic             o_ready,
    input  logic             i_submit,
    input  logic [RW-1:0]    i_data,
    input  logic [RW-1:0]    i_addr,
    input  logic [REGNO-1:0] i_reg_ie,
    input  logic             i_mem_access,
    input  logic             i_mem_we,
    output logic [REGNO-1:0] o_reg_ie,
    output logic [RW-1:0]    o_reg_data,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic [RW-1:0]    o_mem_addr,
    output logic [RW-1:0]    o_mem_data,
    input  logic [RW-1:0]    i_mem_data,
    input  logic             i_mem_ack,
    input  logic             i_mem_err,
    output logic             o_bus_fault,
    output logic [RW-1:0]    o_fault_addr
);

    state_t           state;
    logic [REGNO-1:0] lat_reg_ie;
    logic             in_bus;
    logic             accept_mem;
    logic             tmo_tc;
    logic             term;
    logic             faulted;

    assign in_bus     = (state == BUS);
    assign o_ready    = (state == IDLE);
    assign accept_mem = o_ready && i_submit && i_mem_access;
    assign term       = in_bus && (i_mem_err || i_mem_ack || tmo_tc);
    // Inside a termination, anything but a clean ack (err wins over ack) is a fault.
    assign faulted    = i_mem_err || !i_mem_ack;

    bus_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_tmo (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clear(accept_mem),
        .i_en   (in_bus),
        .o_tc   (tmo_tc)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            o_mem_req    <= 1'b0;
            o_mem_we     <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_data   <= '0;
            lat_reg_ie   <= '0;
            o_bus_fault  <= 1'b0;
            o_fault_addr <= '0;
        end else begin
            o_bus_fault <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept_mem) begin
                        o_mem_req  <= 1'b1;
                        o_mem_we   <= i_mem_we;
                        o_mem_addr <= i_addr;
                        o_mem_data <= i_data;
                        lat_reg_ie <= i_reg_ie;
                        state      <= BUS;
                    end
                end
                BUS: begin
                    if (term) begin
                        o_mem_req <= 1'b0;
                        state     <= IDLE;
                        if (faulted) begin
                            o_bus_fault  <= 1'b1;
                            o_fault_addr <= o_mem_addr;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Single write port: non-mem accepts only in IDLE, load completions only in BUS.
    always_comb begin
        o_reg_ie   = '0;
        o_reg_data = i_data;
        if (o_ready && i_submit && !i_mem_access) begin
            o_reg_ie   = i_reg_ie;
            o_reg_data = i_data;
        end else if (term && !o_mem_we) begin
            o_reg_ie   = lat_reg_ie;
            o_reg_data = faulted ? '0 : i_mem_data;
        end
    end

endmodule

// File: tb/tb_memwb.sv
// Randomized bench for memwb against a transaction-level model, plus directed literal checks.
module tb_memwb;

    localparam int unsigned RW      = 16;
    localparam int unsigned REGNO   = 8;
    localparam int unsigned TIMEOUT = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             ready;
    logic             submit;
    logic [RW-1:0]    data;
    logic [RW-1:0]    addr;
    logic [REGNO-1:0] reg_ie;
    logic             mem_access;
    logic             mem_we_in;
    logic [REGNO-1:0] reg_ie_out;
    logic [RW-1:0]    reg_data;
    logic             mem_req;
    logic             mem_we;
    logic [RW-1:0]    mem_addr;
    logic [RW-1:0]    mem_wdata;
    logic [RW-1:0]    mem_rdata;
    logic             mem_ack;
    logic             mem_err;
    logic             bus_fault;
    logic [RW-1:0]    fault_addr;

    int n_vec  = 0;
    int n_miss = 0;

    memwb #(
        .RW     (RW),
        .REGNO  (REGNO),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .o_ready     (ready),
        .i_submit    (submit),
        .i_data      (data),
        .i_addr      (addr),
        .i_reg_ie    (reg_ie),
        .i_mem_access(mem_access),
        .i_mem_we    (mem_we_in),
        .o_reg_ie    (reg_ie_out),
        .o_reg_data  (reg_data),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_data  (mem_wdata),
        .i_mem_data  (mem_rdata),
        .i_mem_ack   (mem_ack),
        .i_mem_err   (mem_err),
        .o_bus_fault (bus_fault),
        .o_fault_addr(fault_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Transaction-level model: one outstanding transfer and its age in cycles.
    bit               m_valid = 1'b0;
    bit               m_busy;
    int               m_age;
    logic [RW-1:0]    m_addr, m_data, m_faddr;
    logic             m_we;
    logic [REGNO-1:0] m_ie;
    bit               m_fault;

    always @(negedge clk) begin
        bit               done, bad;
        logic [REGNO-1:0] e_ie;
        logic [RW-1:0]    e_data;
        if (m_valid) begin
            done   = m_busy && (mem_err || mem_ack || (TIMEOUT != 0 && m_age == TIMEOUT - 1));
            bad    = mem_err || !mem_ack;
            e_ie   = '0;
            e_data = '0;
            if (!m_busy && submit && !mem_access) begin
                e_ie   = reg_ie;
                e_data = data;
            end else if (done && !m_we) begin
                e_ie   = m_ie;
                e_data = bad ? '0 : mem_rdata;
            end
            check("ready", 32'(ready), 32'(!m_busy));
            check("mem_req", 32'(mem_req), 32'(m_busy));
            if (m_busy) begin
                check("mem_we", 32'(mem_we), 32'(m_we));
                check("mem_addr", 32'(mem_addr), 32'(m_addr));
                check("mem_data", 32'(mem_wdata), 32'(m_data));
            end
            check("reg_ie", 32'(reg_ie_out), 32'(e_ie));
            if (e_ie != 0) check("reg_data", 32'(reg_data), 32'(e_data));
            check("bus_fault", 32'(bus_fault), 32'(m_fault));
            check("fault_addr", 32'(fault_addr), 32'(m_faddr));
        end
        if (rst) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_age   = 0;
            m_fault = 1'b0;
            m_faddr = '0;
        end else if (m_valid) begin
            m_fault = done && bad;
            if (m_fault) m_faddr = m_addr;
            if (m_busy) begin
                if (done) m_busy = 1'b0;
                else      m_age++;
            end else if (submit && mem_access) begin
                m_busy = 1'b1;
                m_age  = 0;
                m_addr = addr;
                m_data = data;
                m_we   = mem_we_in;
                m_ie   = reg_ie;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        submit = 1'b0; mem_access = 1'b0; mem_we_in = 1'b0;
        mem_ack = 1'b0; mem_err = 1'b0; rst = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [RW-1:0] a, input logic [RW-1:0] d,
                         input logic [REGNO-1:0] ie);
        submit = 1'b1; mem_access = 1'b1; mem_we_in = we;
        addr = a; data = d; reg_ie = ie;
        step();
        submit = 1'b0; mem_access = 1'b0;
    endtask

    initial begin
        quiet();
        rst = 1'b1; data = '0; addr = '0; reg_ie = '0; mem_rdata = '0;
        step(); step();
        rst = 1'b0;
        #2;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_fault", 32'(bus_fault), 32'd0);
        check("rst_ie", 32'(reg_ie_out), 32'd0);
        step();

        // Non-memory writeback in the accept cycle
        submit = 1'b1; data = 16'h1234; reg_ie = 8'h04;
        #2;
        check("t1_ie", 32'(reg_ie_out), 32'h04);
        check("t1_data", 32'(reg_data), 32'h1234);
        check("t1_ready", 32'(ready), 32'd1);
        step();
        submit = 1'b0;
        step();

        // Load acked on the third bus cycle
        issue(1'b0, 16'h0100, 16'h0000, 8'h02);
        #2;
        check("t2_req1", 32'(mem_req), 32'd1);
        check("t2_ready1", 32'(ready), 32'd0);
        check("t2_addr", 32'(mem_addr), 32'h0100);
        check("t2_ie1", 32'(reg_ie_out), 32'd0);
        step(); step();
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        #2;
        check("t2_ie", 32'(reg_ie_out), 32'h02);
        check("t2_data", 32'(reg_data), 32'hBEEF);
        check("t2_ready3", 32'(ready), 32'd0);
        step();
        mem_ack = 1'b0;
        #2;
        check("t2_ready_after", 32'(ready), 32'd1);
        check("t2_req_after", 32'(mem_req), 32'd0);
        step();

        // Store: no writeback even with a nonzero reg_ie
        issue(1'b1, 16'h0200, 16'h00AA, 8'h08);
        mem_ack = 1'b1;
        #2;
        check("t3_we", 32'(mem_we), 32'd1);
        check("t3_wdata", 32'(mem_wdata), 32'h00AA);
        check("t3_ie", 32'(reg_ie_out), 32'd0);
        step();
        mem_ack = 1'b0;
        step();

        // Timeout after TIMEOUT request cycles
        issue(1'b0, 16'h0300, 16'h0000, 8'h10);
        for (int i = 0; i < 4; i++) begin
            #2;
            check("t4_req", 32'(mem_req), 32'd1);
            if (i == 3) begin
                check("t4_ie", 32'(reg_ie_out), 32'h10);
                check("t4_data", 32'(reg_data), 32'h0);
            end
            step();
        end
        #2;
        check("t4_fault", 32'(bus_fault), 32'd1);
        check("t4_faddr", 32'(fault_addr), 32'h0300);
        check("t4_req_off", 32'(mem_req), 32'd0);
        step();
        #2;
        check("t4_pulse_end", 32'(bus_fault), 32'd0);
        step();

        // Simultaneous ack and err: err wins
        issue(1'b0, 16'h0400, 16'h0000, 8'h20);
        mem_ack = 1'b1; mem_err = 1'b1; mem_rdata = 16'h5555;
        #2;
        check("t5_ie", 32'(reg_ie_out), 32'h20);
        check("t5_data", 32'(reg_data), 32'h0);
        step();
        mem_ack = 1'b0; mem_err = 1'b0;
        #2;
        check("t5_fault", 32'(bus_fault), 32'd1);
        check("t5_faddr", 32'(fault_addr), 32'h0400);
        step();

        // Reset mid-transfer, then a stray ack
        issue(1'b0, 16'h0500, 16'h0000, 8'h40);
        rst = 1'b1;
        step();
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h7777;
        #2;
        check("t6_req", 32'(mem_req), 32'd0);
        check("t6_ready", 32'(ready), 32'd1);
        check("t6_ie", 32'(reg_ie_out), 32'd0);
        step();
        mem_ack = 1'b0;
        step();

        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            submit     = $urandom_range(0, 1) == 1;
            mem_access = $urandom_range(0, 1) == 1;
            mem_we_in  = $urandom_range(0, 1) == 1;
            addr       = RW'($urandom);
            data       = RW'($urandom);
            reg_ie     = ($urandom_range(0, 3) == 0) ? '0 : REGNO'(1) << $urandom_range(0, REGNO - 1);
            mem_rdata  = RW'($urandom);
            mem_ack    = $urandom_range(0, 2) == 0;
            mem_err    = $urandom_range(0, 9) == 0;
            step();
        end
        quiet();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
